// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
//   Writeback front end for the 32x32 register file. Requests arrive over a
//   valid/ready handshake and are held in an in-order FIFO. The FIFO drains
//   one entry per cycle into the regfile write port whenever that port is
//   granted. Two combinational bypass lookups return the youngest queued value
//   for a register so that decode-stage reads see writes that have not yet
//   been committed.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_wb_valid/o_wb_ready     request handshake; i_wb_addr/i_wb_data payload
//   i_drain_en                regfile write port granted this cycle
//   o_rf_we/addr/data         regfile write port (head of the queue)
//   i_lkp_addrN/o_lkp_hitN/o_lkp_dataN   bypass lookups, N = 1, 2
//   o_empty/o_full/o_count    occupancy status
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wb_valid,
  output logic             o_wb_ready,
  input  logic [4:0]       i_wb_addr,
  input  logic [31:0]      i_wb_data,
  input  logic             i_drain_en,
  output logic             o_rf_we,
  output logic [4:0]       o_rf_addr,
  output logic [31:0]      o_rf_data,
  input  logic [4:0]       i_lkp_addr1,
  input  logic [4:0]       i_lkp_addr2,
  output logic             o_lkp_hit1,
  output logic [31:0]      o_lkp_data1,
  output logic             o_lkp_hit2,
  output logic [31:0]      o_lkp_data2,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [4:0]       addr_q [DEPTH];
  logic [4:0]       addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full, empty, push, pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Writes to x0 are consumed by the handshake but never stored.
  assign push = i_wb_valid && !full && (i_wb_addr != 5'd0);
  assign pop  = !empty && i_drain_en;

  assign o_wb_ready = !full;
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_count    = count_q;
  assign o_rf_we    = pop;
  assign o_rf_addr  = empty ? 5'd0 : addr_q[rd_ptr_q];
  assign o_rf_data  = empty ? 32'd0 : data_q[rd_ptr_q];

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    // A push never lands on the slot being popped: the queue is not empty
    // and not full whenever both happen, so the pointers differ.
    if (push) begin
      addr_d[wr_ptr_q] = i_wb_addr;
      data_d[wr_ptr_q] = i_wb_data;
      vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk from the head towards the write pointer; the last match found is
  // the youngest, so it overrides any older one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = '0;
    o_lkp_hit1  = 1'b0;
    o_lkp_data1 = 32'd0;
    o_lkp_hit2  = 1'b0;
    o_lkp_data2 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (vld_q[idx] && (i_lkp_addr1 != 5'd0) && (addr_q[idx] == i_lkp_addr1)) begin
        o_lkp_hit1  = 1'b1;
        o_lkp_data1 = data_q[idx];
      end
      if (vld_q[idx] && (i_lkp_addr2 != 5'd0) && (addr_q[idx] == i_lkp_addr2)) begin
        o_lkp_hit2  = 1'b1;
        o_lkp_data2 = data_q[idx];
      end
    end
  end

  // Entry payload is qualified by vld_q, so it carries no reset.
  always_ff @(posedge i_clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_wb_valid = 1'b0;
  logic             o_wb_ready;
  logic [4:0]       i_wb_addr = '0;
  logic [31:0]      i_wb_data = '0;
  logic             i_drain_en = 1'b0;
  logic             o_rf_we;
  logic [4:0]       o_rf_addr;
  logic [31:0]      o_rf_data;
  logic [4:0]       i_lkp_addr1 = '0;
  logic [4:0]       i_lkp_addr2 = '0;
  logic             o_lkp_hit1;
  logic [31:0]      o_lkp_data1;
  logic             o_lkp_hit2;
  logic [31:0]      o_lkp_data2;
  logic             o_empty;
  logic             o_full;
  logic [CNT_W-1:0] o_count;

  regfile_wb_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_wb_valid(i_wb_valid), .o_wb_ready(o_wb_ready),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_drain_en(i_drain_en),
    .o_rf_we(o_rf_we), .o_rf_addr(o_rf_addr), .o_rf_data(o_rf_data),
    .i_lkp_addr1(i_lkp_addr1), .i_lkp_addr2(i_lkp_addr2),
    .o_lkp_hit1(o_lkp_hit1), .o_lkp_data1(o_lkp_data1),
    .o_lkp_hit2(o_lkp_hit2), .o_lkp_data2(o_lkp_data2),
    .o_empty(o_empty), .o_full(o_full), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents in commit order, oldest first.
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;
  ent_t mq[$];

  function automatic logic [32:0] model_lookup(input logic [4:0] a);
    logic [32:0] r;
    r = '0;
    if (a != 5'd0)
      foreach (mq[i])
        if (mq[i].addr == a) r = {1'b1, mq[i].data};
    return r;
  endfunction

  always @(negedge i_rst_n) mq.delete();

  always @(posedge i_clk) begin
    if (i_rst_n) begin
      bit m_push, m_pop;
      m_push = i_wb_valid && (mq.size() < DEPTH) && (i_wb_addr != 5'd0);
      m_pop  = i_drain_en && (mq.size() > 0);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back('{addr: i_wb_addr, data: i_wb_data});
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge i_clk) begin
    int n;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    n      = mq.size();
    e_addr = (n > 0) ? mq[0].addr : 5'd0;
    e_data = (n > 0) ? mq[0].data : 32'd0;
    check("rf_port", {27'd0, o_rf_we, o_rf_addr, o_rf_data},
          {27'd0, (n > 0) && i_drain_en, e_addr, e_data});
    check("status", {58'd0, o_empty, o_full, o_wb_ready, o_count},
          {58'd0, n == 0, n == DEPTH, n != DEPTH, CNT_W'(n)});
    check("lkp1", {31'd0, o_lkp_hit1, o_lkp_data1}, {31'd0, model_lookup(i_lkp_addr1)});
    check("lkp2", {31'd0, o_lkp_hit2, o_lkp_data2}, {31'd0, model_lookup(i_lkp_addr2)});
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    i_wb_valid = v;
    i_wb_addr  = a;
    i_wb_data  = d;
  endtask

  logic [4:0]  exp_a [4];
  logic [31:0] exp_d [4];

  initial begin
    exp_a[0] = 5'd5; exp_d[0] = 32'h11;
    exp_a[1] = 5'd6; exp_d[1] = 32'h22;
    exp_a[2] = 5'd5; exp_d[2] = 32'h33;
    exp_a[3] = 5'd7; exp_d[3] = 32'h44;

    // Reset then idle
    step(); step();
    i_rst_n = 1'b1;
    step();
    check("rst_empty", 64'(o_empty), 64'd1);
    check("rst_ready", 64'(o_wb_ready), 64'd1);
    check("rst_we", 64'(o_rf_we), 64'd0);
    check("rst_count", 64'(o_count), 64'd0);

    // Fill with drain disabled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, exp_a[i], exp_d[i]);
      step();
    end
    drive(1'b1, 5'd9, 32'h999);  // must be refused while full
    i_lkp_addr1 = 5'd5;
    i_lkp_addr2 = 5'd8;
    #1;
    check("full_flag", 64'(o_full), 64'd1);
    check("full_ready", 64'(o_wb_ready), 64'd0);
    check("lkp_x5", {31'd0, o_lkp_hit1, o_lkp_data1}, {31'd0, 1'b1, 32'h33});
    check("lkp_x8_hit", 64'(o_lkp_hit2), 64'd0);
    step();
    drive(1'b0, 5'd0, 32'd0);

    // Drain in order
    i_drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_seq", {26'd0, o_rf_we, o_rf_addr, o_rf_data}, {26'd0, 1'b1, exp_a[i], exp_d[i]});
      step();
    end
    #1;
    check("drained_empty", 64'(o_empty), 64'd1);
    check("drained_we", 64'(o_rf_we), 64'd0);

    // x0 write is consumed and dropped
    i_drain_en = 1'b0;
    drive(1'b1, 5'd0, 32'hDEAD);
    #1;
    check("x0_ready", 64'(o_wb_ready), 64'd1);
    step();
    drive(1'b0, 5'd0, 32'd0);
    i_lkp_addr1 = 5'd0;
    #1;
    check("x0_count", 64'(o_count), 64'd0);
    check("x0_lkp", 64'(o_lkp_hit1), 64'd0);

    // Push and pop together at two entries
    drive(1'b1, 5'd1, 32'h1); step();
    drive(1'b1, 5'd2, 32'h2); step();
    drive(1'b1, 5'd9, 32'h99);
    i_drain_en = 1'b1;
    step();
    drive(1'b0, 5'd0, 32'd0);
    #1;
    check("pp_count", 64'(o_count), 64'd2);
    check("pp_head2", 64'(o_rf_addr), 64'd2);
    step();
    #1;
    check("pp_x9", {26'd0, o_rf_we, o_rf_addr, o_rf_data}, {26'd0, 1'b1, 5'd9, 32'h99});
    step();
    #1;
    check("pp_empty", 64'(o_empty), 64'd1);

    // Empty queue: push with drain enabled does not bypass
    drive(1'b1, 5'd3, 32'hAB);
    #1;
    check("nobyp_we", 64'(o_rf_we), 64'd0);
    step();
    drive(1'b0, 5'd0, 32'd0);
    i_lkp_addr1 = 5'd3;
    #1;
    check("byp_port", {26'd0, o_rf_we, o_rf_addr, o_rf_data}, {26'd0, 1'b1, 5'd3, 32'hAB});
    check("byp_lkp", {31'd0, o_lkp_hit1, o_lkp_data1}, {31'd0, 1'b1, 32'hAB});
    step();

    // Reset mid-stream with three entries
    i_drain_en = 1'b0;
    drive(1'b1, 5'd10, 32'hA0); step();
    drive(1'b1, 5'd11, 32'hA1); step();
    drive(1'b1, 5'd12, 32'hA2); step();
    drive(1'b0, 5'd0, 32'd0);
    #1;
    check("pre_rst_count", 64'(o_count), 64'd3);
    i_drain_en = 1'b1;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_count", 64'(o_count), 64'd0);
    check("mid_rst_we", 64'(o_rf_we), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hold_we", 64'(o_rf_we), 64'd0);
    end
    i_rst_n = 1'b1;
    step();
    check("post_rst_empty", 64'(o_empty), 64'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
      i_drain_en  = $urandom_range(0, 2) == 0;
      i_lkp_addr1 = 5'($urandom_range(0, 7));
      i_lkp_addr2 = 5'($urandom_range(0, 7));
      step();
    end
    drive(1'b0, 5'd0, 32'd0);
    i_drain_en = 1'b1;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
